// File: rtl/lcd_nios2_qsys_0_oci_dct_pkg.sv
// Shared types and constants for the Nios II OCI direct-compressed-trace packer.
// The frame word is {count, close reason, packing buffer}.
package lcd_nios2_qsys_0_oci_dct_pkg;

    localparam int DCT_BUF_W   = 30;
    localparam int DCT_FRAME_W = 36;
    localparam int DCT_SLOTS   = 15;
    localparam logic [3:0] DCT_MAX_COUNT = 4'd15;

    typedef enum logic [1:0] {
        COLLECT = 2'b00,
        EMIT    = 2'b01,
        ENDED   = 2'b10
    } dct_state_e;

    localparam logic [1:0] REASON_END     = 2'b00;
    localparam logic [1:0] REASON_FULL    = 2'b01;
    localparam logic [1:0] REASON_FLUSH   = 2'b10;
    localparam logic [1:0] REASON_TIMEOUT = 2'b11;

    function automatic logic [DCT_FRAME_W-1:0] dct_pack_frame(
        input logic [3:0]           count,
        input logic [1:0]           reason,
        input logic [DCT_BUF_W-1:0] buffer
    );
        return {count, reason, buffer};
    endfunction

endpackage

// File: rtl/lcd_nios2_qsys_0_oci_dct_packer_timer.sv
// Saturating idle-cycle counter; expired flags the idle cycle that completes
// a window of FLUSH_TIMEOUT consecutive idle cycles (0 disables it).
module lcd_nios2_qsys_0_oci_dct_timer #(
    parameter int FLUSH_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FLUSH_TIMEOUT);

    logic [CNT_W-1:0] idle_cnt_r;

    // Idle counter: cleared by activity, otherwise counts and holds at the limit
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_r <= '0;
        end else if (clear) begin
            idle_cnt_r <= '0;
        end else if (enable && (idle_cnt_r != LIMIT)) begin
            idle_cnt_r <= idle_cnt_r + CNT_W'(1);
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    // The current idle cycle is the last one of the window when the count is LIMIT-1
    always_comb begin
        if (FLUSH_TIMEOUT == 0) begin
            expired = 1'b0;
        end else begin
            expired = enable && !clear && (idle_cnt_r >= (LIMIT - CNT_W'(1)));
        end
    end

endmodule

// File: rtl/lcd_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace codes into 15-slot frames and hands each frame to trace
// memory over valid/ready; tracks the end-of-test handshake.
module lcd_nios2_qsys_0_oci_dct_packer
    import lcd_nios2_qsys_0_oci_dct_pkg::*;
#(
    parameter int FLUSH_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dct_valid,
    input  logic [1:0]             dct_code,
    output logic                   dct_ready,
    input  logic                   flush_req,
    input  logic                   test_ending,
    output logic [DCT_BUF_W-1:0]   dct_buffer,
    output logic [3:0]             dct_count,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [DCT_FRAME_W-1:0] frame_data,
    output logic                   test_has_ended
);

    dct_state_e             state_r, state_next_s;
    logic [DCT_BUF_W-1:0]   buf_r, buf_next_s, acc_buf_s;
    logic [3:0]             count_r, count_next_s, acc_count_s;
    logic [DCT_FRAME_W-1:0] frame_data_r, frame_data_next_s;
    logic                   end_pending_r, end_pending_next_s;
    logic                   frame_valid_r, dct_ready_r, test_has_ended_r;
    logic                   accept_s, tmr_clear_s, tmr_expired_s;

    assign tmr_clear_s = accept_s || (count_r == 4'd0) || (state_r != COLLECT);

    lcd_nios2_qsys_0_oci_dct_timer #(
        .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear_s),
        .enable  (state_r == COLLECT),
        .expired (tmr_expired_s)
    );

    // Buffer and count as they would look with this cycle's code included
    always_comb begin
        accept_s    = dct_valid && (state_r == COLLECT);
        acc_count_s = count_r + {3'b000, accept_s};
        acc_buf_s   = buf_r;
        for (int k = 0; k < DCT_SLOTS; k++) begin
            acc_buf_s[2*k +: 2] = (accept_s && (count_r == 4'(k))) ? dct_code : buf_r[2*k +: 2];
        end
    end

    // Sequencing: close triggers are prioritised end > full > flush > timeout
    always_comb begin
        state_next_s       = state_r;
        buf_next_s         = buf_r;
        count_next_s       = count_r;
        frame_data_next_s  = frame_data_r;
        end_pending_next_s = end_pending_r;
        case (state_r)
            COLLECT: begin
                buf_next_s   = acc_buf_s;
                count_next_s = acc_count_s;
                if (test_ending) begin
                    if (acc_count_s != 4'd0) begin
                        frame_data_next_s  = dct_pack_frame(acc_count_s, REASON_END, acc_buf_s);
                        end_pending_next_s = 1'b1;
                        state_next_s       = EMIT;
                    end else begin
                        state_next_s = ENDED;
                    end
                end else if (acc_count_s == DCT_MAX_COUNT) begin
                    frame_data_next_s = dct_pack_frame(acc_count_s, REASON_FULL, acc_buf_s);
                    state_next_s      = EMIT;
                end else if (flush_req && (acc_count_s != 4'd0)) begin
                    frame_data_next_s = dct_pack_frame(acc_count_s, REASON_FLUSH, acc_buf_s);
                    state_next_s      = EMIT;
                end else if (tmr_expired_s && (acc_count_s != 4'd0)) begin
                    frame_data_next_s = dct_pack_frame(acc_count_s, REASON_TIMEOUT, acc_buf_s);
                    state_next_s      = EMIT;
                end else begin
                    state_next_s = COLLECT;
                end
            end
            EMIT: begin
                if (test_ending) begin
                    end_pending_next_s = 1'b1;
                end else begin
                    end_pending_next_s = end_pending_r;
                end
                if (frame_ready) begin
                    buf_next_s   = '0;
                    count_next_s = 4'd0;
                    state_next_s = (end_pending_r || test_ending) ? ENDED : COLLECT;
                end else begin
                    state_next_s = EMIT;
                end
            end
            ENDED: begin
                state_next_s = ENDED;
            end
            default: begin
                state_next_s = COLLECT;
            end
        endcase
    end

    // State and registered handshake outputs, all derived from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= COLLECT;
            buf_r            <= '0;
            count_r          <= 4'd0;
            frame_data_r     <= '0;
            end_pending_r    <= 1'b0;
            frame_valid_r    <= 1'b0;
            dct_ready_r      <= 1'b1;
            test_has_ended_r <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            buf_r            <= buf_next_s;
            count_r          <= count_next_s;
            frame_data_r     <= frame_data_next_s;
            end_pending_r    <= end_pending_next_s;
            frame_valid_r    <= (state_next_s == EMIT);
            dct_ready_r      <= (state_next_s == COLLECT);
            test_has_ended_r <= test_has_ended_r || (state_next_s == ENDED);
        end
    end

    assign dct_buffer     = buf_r;
    assign dct_count      = count_r;
    assign frame_data     = frame_data_r;
    assign frame_valid    = frame_valid_r;
    assign dct_ready      = dct_ready_r;
    assign test_has_ended = test_has_ended_r;

endmodule

// File: tb/tb_lcd_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the DCT packer: one instance with an 8-cycle timeout,
// one with the timeout disabled; both share the stimulus.
module tb_lcd_nios2_qsys_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset, dct_valid, flush_req, test_ending, frame_ready;
    logic [1:0]  dct_code;

    logic        a_dct_ready, a_frame_valid, a_test_has_ended;
    logic [29:0] a_dct_buffer;
    logic [3:0]  a_dct_count;
    logic [35:0] a_frame_data;
    logic        b_dct_ready, b_frame_valid, b_test_has_ended;
    logic [29:0] b_dct_buffer;
    logic [3:0]  b_dct_count;
    logic [35:0] b_frame_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lcd_nios2_qsys_0_oci_dct_packer #(.FLUSH_TIMEOUT(8)) dut_a (
        .clk(clk), .reset(reset), .dct_valid(dct_valid), .dct_code(dct_code),
        .dct_ready(a_dct_ready), .flush_req(flush_req), .test_ending(test_ending),
        .dct_buffer(a_dct_buffer), .dct_count(a_dct_count), .frame_valid(a_frame_valid),
        .frame_ready(frame_ready), .frame_data(a_frame_data), .test_has_ended(a_test_has_ended)
    );

    lcd_nios2_qsys_0_oci_dct_packer #(.FLUSH_TIMEOUT(0)) dut_b (
        .clk(clk), .reset(reset), .dct_valid(dct_valid), .dct_code(dct_code),
        .dct_ready(b_dct_ready), .flush_req(flush_req), .test_ending(test_ending),
        .dct_buffer(b_dct_buffer), .dct_count(b_dct_count), .frame_valid(b_frame_valid),
        .frame_ready(frame_ready), .frame_data(b_frame_data), .test_has_ended(b_test_has_ended)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        dct_valid   = 1'b0;
        dct_code    = 2'd0;
        flush_req   = 1'b0;
        test_ending = 1'b0;
        frame_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [1:0] c);
        dct_valid = 1'b1;
        dct_code  = c;
        tick();
        dct_valid = 1'b0;
    endtask

    initial begin
        int first_fv;
        int bad;
        logic seen;

        // Reset values
        do_reset();
        check("rst_fv",    64'(a_frame_valid), 64'd0);
        check("rst_count", 64'(a_dct_count), 64'd0);
        check("rst_buf",   64'(a_dct_buffer), 64'd0);
        check("rst_ready", 64'(a_dct_ready), 64'd1);
        check("rst_data",  64'(a_frame_data), 64'd0);
        check("rst_ended", 64'(a_test_has_ended), 64'd0);

        // Full frame: codes k mod 4 for k = 0..14
        frame_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            dct_valid = 1'b1;
            dct_code  = k[1:0];
            tick();
            if (k == 0) check("full_cnt1", 64'(a_dct_count), 64'd1);
            if (k == 1) check("full_buf2", 64'(a_dct_buffer), 64'h4);
        end
        dct_valid = 1'b0;
        check("full_fv",    64'(a_frame_valid), 64'd1);
        check("full_data",  64'(a_frame_data), 64'({4'd15, 2'b01, 30'h24E4E4E4}));
        check("full_ready", 64'(a_dct_ready), 64'd0);
        tick();
        check("full_hs_fv",    64'(a_frame_valid), 64'd0);
        check("full_hs_count", 64'(a_dct_count), 64'd0);
        check("full_hs_buf",   64'(a_dct_buffer), 64'd0);
        check("full_hs_ready", 64'(a_dct_ready), 64'd1);

        // Flush after three codes, then a flush on an empty buffer
        push(2'd3);
        push(2'd1);
        push(2'd2);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check("flush_fv",   64'(a_frame_valid), 64'd1);
        check("flush_data", 64'(a_frame_data), 64'({4'd3, 2'b10, 24'd0, 6'b10_01_11}));
        tick();
        check("flush_hs_fv", 64'(a_frame_valid), 64'd0);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check("flush_empty0", 64'(a_frame_valid), 64'd0);
        tick();
        check("flush_empty1", 64'(a_frame_valid), 64'd0);

        // Timeout of 8 idle cycles after a single code
        do_reset();
        push(2'd1);
        first_fv = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (a_frame_valid && (first_fv == 0)) first_fv = i;
        end
        check("tmo_cycles", 64'(first_fv), 64'd8);
        check("tmo_data",   64'(a_frame_data), 64'({4'd1, 2'b11, 30'd1}));

        // Timeout disabled: nothing after 100 idle cycles
        do_reset();
        push(2'd1);
        seen = 1'b0;
        repeat (100) begin
            tick();
            if (b_frame_valid) seen = 1'b1;
        end
        check("tmo0_noframe", 64'(seen), 64'd0);
        check("tmo0_count",   64'(b_dct_count), 64'd1);

        // Backpressure: frame held for 20 cycles while a code waits
        do_reset();
        push(2'd2);
        push(2'd3);
        push(2'd0);
        push(2'd1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        dct_valid = 1'b1;
        dct_code  = 2'd3;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ((a_frame_data !== {4'd4, 2'b10, 30'h4E}) || (a_dct_ready !== 1'b0) ||
                (a_dct_count !== 4'd4) || (a_frame_valid !== 1'b1)) bad++;
        end
        check("bp_stable", 64'(bad), 64'd0);
        check("bp_data",   64'(a_frame_data), 64'({4'd4, 2'b10, 30'h4E}));
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("bp_ready_back", 64'(a_dct_ready), 64'd1);
        check("bp_count_clr",  64'(a_dct_count), 64'd0);
        tick();
        dct_valid = 1'b0;
        check("bp_kept_count", 64'(a_dct_count), 64'd1);
        check("bp_kept_buf",   64'(a_dct_buffer), 64'd3);

        // End of test with five codes pending
        do_reset();
        repeat (5) push(2'd1);
        test_ending = 1'b1;
        tick();
        check("end_fv",     64'(a_frame_valid), 64'd1);
        check("end_data",   64'(a_frame_data), 64'({4'd5, 2'b00, 30'h155}));
        check("end_early",  64'(a_test_has_ended), 64'd0);
        frame_ready = 1'b1;
        tick();
        check("end_done",   64'(a_test_has_ended), 64'd1);
        check("end_fv_low", 64'(a_frame_valid), 64'd0);
        check("end_ready",  64'(a_dct_ready), 64'd0);
        frame_ready = 1'b0;
        tick();
        check("end_sticky", 64'(a_test_has_ended), 64'd1);

        // End of test with an empty buffer
        do_reset();
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        check("end0_done", 64'(a_test_has_ended), 64'd1);
        check("end0_fv",   64'(a_frame_valid), 64'd0);

        // Reset while a frame is waiting
        do_reset();
        push(2'd3);
        push(2'd2);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check("mrst_pre_fv", 64'(a_frame_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_fv",    64'(a_frame_valid), 64'd0);
        check("mrst_count", 64'(a_dct_count), 64'd0);
        check("mrst_buf",   64'(a_dct_buffer), 64'd0);
        check("mrst_ready", 64'(a_dct_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
